cp0_regfile: RTL
================

Name: cp0_regfile

Overview:
- System Control Coprocessor (CP0) register file for the MIPS pipeline.
- Receives the per-cycle exception commit from the exception detector and applies it: EXL, ExcCode, BD, EPC and BadVAddr updates.
- Also serves MTC0/MFC0 accesses, applies ERET, runs the Count/Compare timer and samples hardware interrupt lines.
- Feeds Status/Cause/EPC back to the exception detector and the PC-select logic.

Parameters:
- COUNT_RESET, 32'h0000_0000, reset value of Count.
- STATUS_RESET, 32'h0040_0000, reset value of Status (BEV=1).

Ports:
- clk  in  1  single clock; every register updates on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- exception_occur  in  1  commit of a precise exception this cycle.
- ExcCode  in  5  cause code to record.
- is_ds  in  1  faulting instruction is in a delay slot.
- epc_in  in  32  EPC value computed by the exception detector.
- badvaddr_we  in  1  load BadVAddr this cycle.
- badvaddr_in  in  32  faulting address.
- isERET  in  1  ERET commits this cycle.
- mtc0_we  in  1  MTC0 write strobe.
- cp0_waddr  in  5  MTC0 register number (sel fixed 0).
- cp0_wdata  in  32  MTC0 data.
- cp0_raddr  in  5  MFC0 register number.
- cp0_rdata  out  32  MFC0 data.
- hw_int  in  6  external interrupt lines, level-sensitive.
- Status  out  32  current Status.
- Cause  out  32  current Cause.
- EPC  out  32  current EPC.
- interrupt_pending  out  1  enabled, unmasked interrupt present.

Behaviour:
- Registers implemented: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14).
- Reset values: Count=COUNT_RESET; Status=STATUS_RESET; all other registers, tick and hw_int_q are 0. Outputs reset accordingly; interrupt_pending=0.
- Write priority per cycle, highest first: exception_occur > isERET > mtc0_we. A lower-priority write in the same cycle is dropped entirely. Exception: Count/Compare/timer updates still proceed.
- Exception commit:
  - Status.EXL<=1.
  - Cause[6:2]<=ExcCode.
  - Cause.BD(31)<=is_ds.
  - EPC<=epc_in.
  - If badvaddr_we, BadVAddr<=badvaddr_in.
  - Visible on outputs the next cycle (1-cycle latency).
- ERET: Status.EXL<=0. No other field changes.
- MTC0 writable fields:
  - Status: IM[15:8], EXL[1], IE[0]. Other bits are read-only and hold their values.
  - Cause: IP[9:8] only.
  - EPC, Count, Compare: full 32 bits.
  - BadVAddr and unimplemented numbers: write ignored.
- MFC0 read: combinational on cp0_raddr from current register state (no write bypass). Unimplemented numbers read 0.
- Interrupt sampling: hw_int registered into hw_int_q each cycle. Cause.IP[7:2] = {hw_int_q[5] | Cause.TI, hw_int_q[4:0]}, refreshed every cycle and never written by MTC0.
- Timer:
  - A 1-bit tick toggles every cycle; Count increments when tick==1 (half clock rate). Count wraps from 0xFFFF_FFFF to 0.
  - TI (Cause bit 30) is set when an increment produces Count==Compare.
  - TI is sticky; it is cleared only by an MTC0 to Compare.
  - MTC0 to Count loads cp0_wdata and clears tick. A simultaneous increment is discarded.
  - A Count write alone never sets TI.
- interrupt_pending = Status.IE & ~Status.EXL & |(Cause[15:8] & Status[15:8]), combinational from registers.
- resetn asserted mid-operation clears all state immediately, including a pending TI.

Optional Feature:
- Macro: CP0_TIMER_EN.
- Defined: Count/Compare/tick/TI implemented exactly as above.
- Undefined:
  - Count and Compare are absent and read 0; MTC0 to them is ignored.
  - TI is constant 0.
  - IP[7] = hw_int_q[5].

Decomposition:
- Shared package cp0_pkg holds:
  - CP0 register numbers: CP0_BADVADDR=8, CP0_COUNT=9, CP0_COMPARE=11, CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14.
  - Status/Cause bit-position constants: EXL=1, IE=0, IM=15:8, BD=31, TI=30, IP=15:8, EXC=6:2.
  - ExcCode constants: Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12.
- One sub-module, cp0_timer: Count, Compare, tick and TI, with ports for write strobes and TI clear. Instantiated only under CP0_TIMER_EN.

Test Plan:
- Reset release -> Status=0x0040_0000, Cause=0, EPC=0, cp0_rdata(12)=0x0040_0000, interrupt_pending=0.
- exception_occur=1, ExcCode=5'd4, is_ds=1, epc_in=0xBFC0_0100, badvaddr_we=1, badvaddr_in=0x1234_5671 -> next cycle Status.EXL=1, Cause=0x8000_0010, EPC=0xBFC0_0100, BadVAddr=0x1234_5671.
- Same cycle: exception_occur=1 and mtc0_we to EPC with 0xDEAD_BEEF -> EPC=epc_in; MTC0 is lost. Then isERET=1 -> EXL=0, EPC unchanged.
- MTC0 Status=0x0000_0301, then MTC0 Cause=0x0000_0100 -> Cause.IP[0]=1 and interrupt_pending=1. Setting EXL via MTC0 Status=0x0000_0303 -> interrupt_pending=0.
- (CP0_TIMER_EN) Count=0, Compare=5 -> TI and Cause.IP[7] set 10 cycles after the Compare write. MTC0 Compare=100 -> TI cleared next cycle. Count=0xFFFF_FFFF wraps to 0.
- hw_int=6'b000010 with Status=0x0000_0801 -> Cause.IP[3]=1 one cycle later, interrupt_pending=1. Drop hw_int -> both cleared one cycle later.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, Status/Cause field positions and exception codes.
package cp0_pkg;

  // CP0 register numbers (select 0)
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  // Status field positions
  localparam int unsigned STATUS_IE     = 0;
  localparam int unsigned STATUS_EXL    = 1;
  localparam int unsigned STATUS_IM_LSB = 8;
  localparam int unsigned STATUS_IM_MSB = 15;

  // Cause field positions
  localparam int unsigned CAUSE_EXC_LSB = 2;
  localparam int unsigned CAUSE_EXC_MSB = 6;
  localparam int unsigned CAUSE_IP_LSB  = 8;
  localparam int unsigned CAUSE_IP_MSB  = 15;
  localparam int unsigned CAUSE_TI      = 30;
  localparam int unsigned CAUSE_BD      = 31;

  // Status bits software may change: IM, EXL, IE
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  // Exception codes
  typedef enum logic [4:0] {
    ExcInt  = 5'd0,
    ExcAdEL = 5'd4,
    ExcAdES = 5'd5,
    ExcSys  = 5'd8,
    ExcBp   = 5'd9,
    ExcRI   = 5'd10,
    ExcOv   = 5'd12
  } exc_code_e;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count advances every other cycle, TI latches on a compare match.
module cp0_timer #(
  parameter logic [31:0] COUNT_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tick_q, tick_d;
  logic        ti_q, ti_d;
  logic [31:0] count_inc;
  logic        match;

  assign count_inc = count_q + 32'd1;

  // Next-state: a Count write overrides the increment and restarts the half-rate tick
  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    tick_d    = ~tick_q;
    match     = 1'b0;
    if (count_we) begin
      count_d = wdata;
      tick_d  = 1'b0;
    end else if (tick_q) begin
      count_d = count_inc;
      match   = (count_inc == compare_q);
    end
    if (compare_we) begin
      compare_d = wdata;
    end
    // Writing Compare is the only way to acknowledge the timer interrupt
    ti_d = compare_we ? 1'b0 : (ti_q | match);
  end

  // Timer state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q   <= COUNT_RESET;
      compare_q <= 32'h0000_0000;
      tick_q    <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      tick_q    <= tick_d;
      ti_q      <= ti_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: exception commit, ERET, MTC0/MFC0, interrupt sampling.
// Optional Count/Compare timer is built when CP0_TIMER_EN is defined.
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter logic [31:0] COUNT_RESET  = 32'h0000_0000,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        exception_occur,
  input  logic [4:0]  ExcCode,
  input  logic        is_ds,
  input  logic [31:0] epc_in,
  input  logic        badvaddr_we,
  input  logic [31:0] badvaddr_in,
  input  logic        isERET,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic [4:0]  cp0_raddr,
  output logic [31:0] cp0_rdata,
  input  logic [5:0]  hw_int,
  output logic [31:0] Status,
  output logic [31:0] Cause,
  output logic [31:0] EPC,
  output logic        interrupt_pending
);

  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic        bd_q, bd_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [5:0]  hw_int_q;

  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;
  logic [7:0]  ip;

`ifdef CP0_TIMER_EN
  logic count_we;
  logic compare_we;

  // Timer writes are not subject to exception/ERET priority
  assign count_we   = mtc0_we && (cp0_waddr == CP0_COUNT);
  assign compare_we = mtc0_we && (cp0_waddr == CP0_COMPARE);

  cp0_timer #(
    .COUNT_RESET (COUNT_RESET)
  ) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .count_we   (count_we),
    .compare_we (compare_we),
    .wdata      (cp0_wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );
`else
  logic unused_count_reset;

  assign count   = 32'h0000_0000;
  assign compare = 32'h0000_0000;
  assign ti      = 1'b0;
  assign unused_count_reset = ^COUNT_RESET;
`endif

  // Next-state: exception beats ERET beats MTC0; a losing write is dropped
  always_comb begin
    status_d   = status_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    exc_code_d = exc_code_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    if (exception_occur) begin
      status_d[STATUS_EXL] = 1'b1;
      exc_code_d           = ExcCode;
      bd_d                 = is_ds;
      epc_d                = epc_in;
      if (badvaddr_we) begin
        badvaddr_d = badvaddr_in;
      end
    end else if (isERET) begin
      status_d[STATUS_EXL] = 1'b0;
    end else if (mtc0_we) begin
      case (cp0_waddr)
        CP0_STATUS: status_d = (status_q & ~STATUS_WMASK) | (cp0_wdata & STATUS_WMASK);
        CP0_CAUSE:  ip_sw_d  = cp0_wdata[9:8];
        CP0_EPC:    epc_d    = cp0_wdata;
        default:    ;
      endcase
    end
  end

  // Architectural register state and interrupt line sampling
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_q   <= STATUS_RESET;
      epc_q      <= 32'h0000_0000;
      badvaddr_q <= 32'h0000_0000;
      exc_code_q <= 5'd0;
      bd_q       <= 1'b0;
      ip_sw_q    <= 2'b00;
      hw_int_q   <= 6'b00_0000;
    end else begin
      status_q   <= status_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      exc_code_q <= exc_code_d;
      bd_q       <= bd_d;
      ip_sw_q    <= ip_sw_d;
      hw_int_q   <= hw_int;
    end
  end

  // Hardware IP bits track the sampled lines every cycle; IP[7] is shared with the timer
  always_comb begin
    ip = {hw_int_q[5] | ti, hw_int_q[4:0], ip_sw_q};
  end

  // Cause assembled from its fields
  always_comb begin
    Cause                              = 32'h0000_0000;
    Cause[CAUSE_BD]                    = bd_q;
    Cause[CAUSE_TI]                    = ti;
    Cause[CAUSE_IP_MSB:CAUSE_IP_LSB]   = ip;
    Cause[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = exc_code_q;
  end

  // MFC0 read mux, no bypass of same-cycle writes
  always_comb begin
    case (cp0_raddr)
      CP0_BADVADDR: cp0_rdata = badvaddr_q;
      CP0_COUNT:    cp0_rdata = count;
      CP0_COMPARE:  cp0_rdata = compare;
      CP0_STATUS:   cp0_rdata = status_q;
      CP0_CAUSE:    cp0_rdata = Cause;
      CP0_EPC:      cp0_rdata = epc_q;
      default:      cp0_rdata = 32'h0000_0000;
    endcase
  end

  // Interrupt request towards the exception detector
  always_comb begin
    interrupt_pending = status_q[STATUS_IE] & ~status_q[STATUS_EXL] &
                        (|(Cause[CAUSE_IP_MSB:CAUSE_IP_LSB] &
                           status_q[STATUS_IM_MSB:STATUS_IM_LSB]));
  end

  assign Status = status_q;
  assign EPC    = epc_q;

endmodule
